// File: rtl/ads_int_to_float_pkg.sv
// Shared float constants and handshake state encodings for the float filter chain.
// ST_IDLE / ST_FINISH keep the same encodings in every block of the chain.
package ads_int_to_float_pkg;

    localparam int          FLT_BIAS   = 127;
    localparam int          FLT_MANT_W = 23;
    localparam logic [31:0] FLT_ZERO   = 32'h0000_0000;

    localparam int          MAG_W      = 24;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ABS    = 3'd1,
        ST_NORM   = 3'd2,
        ST_PACK   = 3'd3,
        ST_FINISH = 3'd4
    } hs_state_e;

endpackage

// File: rtl/ads_int_to_float_if.sv
// Sample-in / float-out handshake bundle between the ADS1292 readout and the IIR chain.
// X side: sample moves on the edge where i_X_DATA_VALID && o_X_DATA_READY; Y side: o_Y_DATA is held with o_Y_DATA_VALID until the edge where i_Y_ACK is seen.
interface ads_int_to_float_if #(
    parameter int P_IN_WIDTH = 24
) ();
    import ads_int_to_float_pkg::*;

    logic [P_IN_WIDTH-1:0] i_X_DATA;
    logic                  i_X_DATA_VALID;
    logic                  o_X_DATA_READY;
    logic [31:0]           o_Y_DATA;
    logic                  o_Y_DATA_VALID;
    logic                  i_Y_ACK;
    hs_state_e             o_DBG_STATE;

    modport slave (
        input  i_X_DATA,
        input  i_X_DATA_VALID,
        output o_X_DATA_READY,
        output o_Y_DATA,
        output o_Y_DATA_VALID,
        input  i_Y_ACK,
        output o_DBG_STATE
    );

    modport master (
        output i_X_DATA,
        output i_X_DATA_VALID,
        input  o_X_DATA_READY,
        input  o_Y_DATA,
        input  o_Y_DATA_VALID,
        output i_Y_ACK,
        input  o_DBG_STATE
    );

endinterface

// File: rtl/ads_int_to_float.sv
// Exact signed-integer to IEEE-754 single converter, scaled by 2^-P_FRAC_SHIFT.
// Normalises one bit per cycle with a shift register and an exponent down-counter.
module ads_int_to_float
    import ads_int_to_float_pkg::*;
#(
    parameter int P_IN_WIDTH   = 24,
    parameter int P_FRAC_SHIFT = 0
) (
    input  logic                    i_CLK,
    input  logic                    i_RSTN,
    ads_int_to_float_if.slave       io
);

    // Exponent of a value whose leading one already sits at bit 23, before normalising.
    localparam logic [7:0] EXP_INIT = 8'(FLT_BIAS + FLT_MANT_W - P_FRAC_SHIFT);

    hs_state_e          state_q;
    logic [MAG_W-1:0]   x_q;
    logic [MAG_W-1:0]   mag_q;
    logic               sign_q;
    logic [7:0]         exp_q;
    logic [31:0]        y_q;
    logic               ready_q;
    logic               valid_q;

    logic signed [P_IN_WIDTH-1:0] x_s;
    logic [MAG_W-1:0]             x_d;
    logic [MAG_W-1:0]             mag_d;

    assign x_s   = io.i_X_DATA;
    assign x_d   = MAG_W'(x_s);
    // -2^23 negates to 0x800000, which is the correct unsigned magnitude.
    assign mag_d = x_q[MAG_W-1] ? (~x_q + 24'd1) : x_q;

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            mag_q   <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            y_q     <= FLT_ZERO;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (io.i_X_DATA_VALID && ready_q) begin
                        x_q     <= x_d;
                        ready_q <= 1'b0;
                        state_q <= ST_ABS;
                    end
                end
                ST_ABS: begin
                    sign_q  <= x_q[MAG_W-1];
                    mag_q   <= mag_d;
                    exp_q   <= EXP_INIT;
                    state_q <= (mag_d == '0) ? ST_PACK : ST_NORM;
                end
                ST_NORM: begin
                    if (mag_q[MAG_W-1]) begin
                        state_q <= ST_PACK;
                    end else begin
                        mag_q <= mag_q << 1;
                        exp_q <= exp_q - 8'd1;
                    end
                end
                ST_PACK: begin
                    // Zero carries a non-zero exponent here, so force +0 explicitly.
                    y_q     <= (mag_q == '0) ? FLT_ZERO
                                             : {sign_q, exp_q, mag_q[FLT_MANT_W-1:0]};
                    state_q <= ST_FINISH;
                end
                ST_FINISH: begin
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (io.i_Y_ACK) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign io.o_X_DATA_READY = ready_q;
    assign io.o_Y_DATA       = y_q;
    assign io.o_Y_DATA_VALID = valid_q;
    assign io.o_DBG_STATE    = state_q;

endmodule
